// File: rtl/onehot_enc_pkg.sv
// ----------------------------------------------------------------------------
// onehot_enc_pkg
// Shared definitions for the 16-bit select-vector serializer:
//   VEC_W / IDX_W   vector and index widths
//   state_t         serializer FSM states
//   popcnt_is_one() true when exactly one bit of a vector is set
// ----------------------------------------------------------------------------
package onehot_enc_pkg;

    localparam int VEC_W = 16;
    localparam int IDX_W = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // v & (v-1) clears the lowest set bit; zero afterwards means at most one bit was set
    function automatic logic popcnt_is_one(input logic [15:0] v);
        return (v != 16'd0) && ((v & (v - 16'd1)) == 16'd0);
    endfunction

endpackage

// File: rtl/pri_enc16.sv
// ----------------------------------------------------------------------------
// pri_enc16
// Combinational 16-to-4 priority encoder.
// Default build: returns the index of the lowest set bit.
// With ONEHOT_ENC_MSB_FIRST_EN defined: returns the index of the highest set bit.
// Ports:
//   vec  in  16  vector to encode
//   idx  out 4   index of the winning set bit (0 when vec is zero)
//   any  out 1   at least one bit of vec is set
// ----------------------------------------------------------------------------
module pri_enc16
    import onehot_enc_pkg::*;
(
    input  logic [15:0] vec,
    output logic [3:0]  idx,
    output logic        any
);

    // Priority scan: the last matching bit in loop order wins
    always_comb begin
        idx = 4'd0;
        any = |vec;
`ifdef ONEHOT_ENC_MSB_FIRST_EN
        for (int i = 0; i < 16; i++) begin
            if (vec[i]) begin
                idx = 4'(i);
            end else begin
                idx = idx;
            end
        end
`else
        for (int i = 15; i >= 0; i--) begin
            if (vec[i]) begin
                idx = 4'(i);
            end else begin
                idx = idx;
            end
        end
`endif
    end

endmodule

// File: rtl/onehot_enc16_ser.sv
// ----------------------------------------------------------------------------
// onehot_enc16_ser
// Accepts a 16-bit one-hot/multi-hot select vector per input handshake and
// emits the index of each set bit, one per output handshake.
// Scan order: lowest set bit first by default; highest set bit first when
// the macro ONEHOT_ENC_MSB_FIRST_EN is defined.
// Ports:
//   clk        in   1   rising-edge clock
//   rst        in   1   synchronous active-high reset
//   in_valid   in   1   in_vec is presented
//   in_ready   out  1   block can accept a vector (IDLE)
//   in_vec     in   16  select vector, bit i -> index i
//   out_valid  out  1   out_idx is valid (BUSY)
//   out_ready  in   1   consumer accepts out_idx
//   out_idx    out  4   index of the current set bit
//   out_last   out  1   current index is the final set bit of the vector
//   out_seq    out  4   beat number within the vector
//   zero_drop  out  1   one-cycle pulse after an all-zero vector is discarded
// ----------------------------------------------------------------------------
module onehot_enc16_ser #(
    parameter int VEC_W = 16,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [VEC_W-1:0] in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic [IDX_W-1:0] out_seq,
    output logic             zero_drop
);

    import onehot_enc_pkg::*;

    state_t           state_r;
    logic [15:0]      pending_r;
    logic [3:0]       seq_r;
    logic             zero_drop_r;
    logic [3:0]       enc_idx_s;
    logic             enc_any_s;
    logic             busy_s;
    logic             last_s;

    pri_enc16 u_pri_enc16 (
        .vec (pending_r),
        .idx (enc_idx_s),
        .any (enc_any_s)
    );

    // Decode of registered state only; no input reaches an output combinationally
    always_comb begin
        busy_s = (state_r == BUSY);
        last_s = busy_s && popcnt_is_one(pending_r);
    end

    assign in_ready  = !busy_s;
    assign out_valid = busy_s;
    assign out_idx   = busy_s ? enc_idx_s : 4'd0;
    assign out_last  = last_s;
    assign out_seq   = busy_s ? seq_r : 4'd0;
    assign zero_drop = zero_drop_r;

    // Serializer FSM: vector capture, per-beat bit clearing and beat counting
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            pending_r   <= 16'd0;
            seq_r       <= 4'd0;
            zero_drop_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    zero_drop_r <= in_valid && (in_vec == 16'd0);
                    if (in_valid && (in_vec != 16'd0)) begin
                        pending_r <= in_vec;
                        seq_r     <= 4'd0;
                        state_r   <= BUSY;
                    end else begin
                        state_r   <= IDLE;
                    end
                end
                BUSY: begin
                    zero_drop_r <= 1'b0;
                    if (out_ready && enc_any_s) begin
                        pending_r <= pending_r & ~(16'd1 << enc_idx_s);
                        if (last_s) begin
                            seq_r   <= 4'd0;
                            state_r <= IDLE;
                        end else begin
                            // 4-bit counter wraps naturally after 15
                            seq_r   <= seq_r + 4'd1;
                        end
                    end else begin
                        state_r <= BUSY;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    pending_r   <= 16'd0;
                    seq_r       <= 4'd0;
                    zero_drop_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_onehot_enc16_ser.sv
// ----------------------------------------------------------------------------
// tb_onehot_enc16_ser
// Directed bench for onehot_enc16_ser with a queue-based reference model and
// literal expectations for the listed scenarios. Honours ONEHOT_ENC_MSB_FIRST_EN.
// ----------------------------------------------------------------------------
module tb_onehot_enc16_ser;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_vec = 16'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [3:0]  out_idx;
    logic        out_last;
    logic [3:0]  out_seq;
    logic        zero_drop;

    int checks = 0;
    int errors = 0;

    onehot_enc16_ser dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_vec    (in_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .out_seq   (out_seq),
        .zero_drop (zero_drop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: list of indices still to be emitted, in scan order
    int  m_q[$];
    int  m_seq = 0;
    bit  m_zd  = 1'b0;
    bit  m_ok  = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_q.delete();
            m_seq = 0;
            m_zd  = 1'b0;
            m_ok  = 1'b1;
        end else if (m_q.size() == 0) begin
            m_zd = in_valid && (in_vec == 16'd0);
            if (in_valid && (in_vec != 16'd0)) begin
                for (int b = 0; b < 16; b++) begin
                    if (in_vec[b]) begin
`ifdef ONEHOT_ENC_MSB_FIRST_EN
                        m_q.push_front(b);
`else
                        m_q.push_back(b);
`endif
                    end
                end
                m_seq = 0;
            end
        end else begin
            m_zd = 1'b0;
            if (out_ready) begin
                void'(m_q.pop_front());
                m_seq = (m_q.size() == 0) ? 0 : (m_seq + 1) % 16;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (m_ok) begin
            chk("m_in_ready",  int'(in_ready),  int'(m_q.size() == 0));
            chk("m_out_valid", int'(out_valid), int'(m_q.size() != 0));
            chk("m_out_idx",   int'(out_idx),   (m_q.size() != 0) ? m_q[0] : 0);
            chk("m_out_last",  int'(out_last),  int'(m_q.size() == 1));
            chk("m_out_seq",   int'(out_seq),   (m_q.size() != 0) ? m_seq : 0);
            chk("m_zero_drop", int'(zero_drop), int'(m_zd));
        end
    end

    // Present a vector for exactly one edge; returns #2 after the acceptance edge
    task automatic send(input logic [15:0] v);
        in_valid = 1'b1;
        in_vec   = v;
        @(posedge clk); #2;
        in_valid = 1'b0;
        in_vec   = 16'd0;
    endtask

    task automatic step();
        @(posedge clk); #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int e8421 [4];
        int e0110 [2];
        int ex;
`ifdef ONEHOT_ENC_MSB_FIRST_EN
        e8421 = '{15, 10, 5, 0};
        e0110 = '{8, 4};
`else
        e8421 = '{0, 5, 10, 15};
        e0110 = '{4, 8};
`endif
        // Reset held two cycles
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        chk("rst_in_ready",  int'(in_ready),  1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_zero_drop", int'(zero_drop), 0);
        chk("rst_out_seq",   int'(out_seq),   0);
        step();

        // Single-bit vector
        out_ready = 1'b1;
        send(16'h0001);
        chk("one_idx",   int'(out_idx),   0);
        chk("one_last",  int'(out_last),  1);
        chk("one_seq",   int'(out_seq),   0);
        chk("one_valid", int'(out_valid), 1);
        step();
        chk("one_ready_after", int'(in_ready), 1);

        // Four-bit vector, continuous ready
        send(16'h8421);
        for (int k = 0; k < 4; k++) begin
            chk("v8421_idx",  int'(out_idx),  e8421[k]);
            chk("v8421_seq",  int'(out_seq),  k);
            chk("v8421_last", int'(out_last), int'(k == 3));
            step();
        end
        chk("v8421_idle", int'(in_ready), 1);

        // Backpressure: first index held while ready is low
        out_ready = 1'b0;
        send(16'h0110);
        for (int k = 0; k < 3; k++) begin
            chk("bp_hold_idx",  int'(out_idx),  e0110[0]);
            chk("bp_hold_last", int'(out_last), 0);
            chk("bp_hold_seq",  int'(out_seq),  0);
            if (k < 2) step();
        end
        out_ready = 1'b1;
        step();
        chk("bp_idx2",  int'(out_idx),  e0110[1]);
        chk("bp_last2", int'(out_last), 1);
        chk("bp_seq2",  int'(out_seq),  1);
        step();
        chk("bp_idle", int'(out_valid), 0);

        // All-zero vector is dropped with a one-cycle pulse
        send(16'h0000);
        chk("zd_pulse",     int'(zero_drop), 1);
        chk("zd_valid",     int'(out_valid), 0);
        chk("zd_ready",     int'(in_ready),  1);
        step();
        chk("zd_pulse_end", int'(zero_drop), 0);
        chk("zd_ready2",    int'(in_ready),  1);

        // Full vector: 16 beats, seq 0..15
        send(16'hFFFF);
        for (int k = 0; k < 16; k++) begin
`ifdef ONEHOT_ENC_MSB_FIRST_EN
            ex = 15 - k;
`else
            ex = k;
`endif
            chk("full_idx",  int'(out_idx),  ex);
            chk("full_seq",  int'(out_seq),  k);
            chk("full_last", int'(out_last), int'(k == 15));
            step();
        end
        chk("full_idle", int'(in_ready), 1);

        // Reset in the middle of a vector, then a fresh vector
        send(16'hFFFF);
        for (int k = 0; k < 5; k++) step();
        chk("mid_seq_before_rst", int'(out_seq), 5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_valid", int'(out_valid), 0);
        chk("mid_rst_seq",   int'(out_seq),   0);
        chk("mid_rst_ready", int'(in_ready),  1);
        send(16'h0004);
        chk("post_idx",  int'(out_idx),  2);
        chk("post_last", int'(out_last), 1);
        chk("post_seq",  int'(out_seq),  0);
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
